gbuf_loader: RTL
================

# gbuf_loader

Upstream feeder for the TPU core. Accepts a byte stream from the host (a 3-byte header K, M, N followed by pre-ordered int8 operands), packs bytes into 32-bit words, and writes them into the A and B global buffers through the same write ports the TPU uses. It then issues the single-cycle `in_valid` start pulse with K/M/N, waits for the TPU's `busy` to rise and fall, and reports completion.

## Interface
- ADDR_W, 16, width of buffer index outputs
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- s_valid  input  1  host byte valid
- s_data  input  8  host byte
- s_ready  output  1  loader accepts byte this cycle (transfer = s_valid & s_ready)
- A_wr_en  output  1  A buffer write strobe
- A_index  output  ADDR_W  A buffer word address
- A_data_in  output  32  A buffer write data
- B_wr_en  output  1  B buffer write strobe
- B_index  output  ADDR_W  B buffer word address
- B_data_in  output  32  B buffer write data
- in_valid  output  1  TPU start pulse
- K, M, N  output  8 each  matrix dims to TPU, held stable from start pulse until done
- busy  input  1  TPU busy
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse: zero dimension in header

## Operation
- States: IDLE, HDR_M, HDR_N, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO.
- IDLE: s_ready=1; accepted byte latched as K -> HDR_M. HDR_M latches M -> HDR_N. HDR_N latches N; if K, M or N is 0 -> err pulse next cycle, back to IDLE; else -> LOAD_A.
- Word counts: A_words = ((M+3)>>2)*K, B_words = ((N+3)>>2)*K; computed at header end, max 16320, fits 16 bits.
- Packing: bytes arrive MSB first; byte 0 of a word -> bits [31:24], byte 3 -> [7:0]. Host supplies data already in buffer order (word index = block*K + k, lane = row/col mod 4); loader does no reordering. Padding lanes for M or N not divisible by 4 are sent by host as real bytes.
- LOAD_A: s_ready=1; on 4th byte of a word, write issued; index increments from 0. After write of word A_words-1 -> LOAD_B. LOAD_B identical on B port; after word B_words-1 -> START.
- START: in_valid=1 for exactly one cycle -> WAIT_HI.
- WAIT_HI: waits for busy=1 -> WAIT_LO. WAIT_LO: waits for busy=0 -> IDLE with done=1 that cycle.
- s_ready=0 in START, WAIT_HI, WAIT_LO. Bytes offered then are not consumed.
- s_valid low mid-word: partial byte count and partial word held indefinitely.

## Timing
- Reset values: s_ready=0 during reset, 1 first cycle after release (IDLE); all strobes, indices, data, K/M/N, done, err = 0.
- Write latency: byte completing a word accepted at edge t; A_wr_en/B_wr_en high with registered index/data during cycle t..t+1 (one cycle), low otherwise. Back-to-back words never produce consecutive wr_en cycles (min 4 cycles apart).
- Last B write cycle is followed immediately by in_valid cycle (START); no gap, no overlap.
- busy sampled from cycle after in_valid. busy already low in WAIT_HI: loader waits (no timeout).
- done asserted in the cycle IDLE is re-entered; next header byte may be accepted that same cycle.
- A and B write strobes never high in the same cycle.
- Reset mid-operation: all state, counters, partial word discarded asynchronously; outputs to reset values immediately; no write completes.

## Test plan
- K=2,M=4,N=4; bytes 02 04 04, 01..08, 10..17 -> A[0]=0x01020304, A[1]=0x05060708, B[0]=0x10111213, B[1]=0x14151617; in_valid one cycle after B[1] write with K=2,M=4,N=4; busy pulse of 5 cycles -> done one cycle after busy falls.
- K=3,M=5,N=1 -> exactly 6 A writes (index 0..5), 3 B writes (0..2), then in_valid.
- Header 00 04 04 -> err pulse, no writes, no in_valid, s_ready stays high, returns to IDLE.
- Random s_valid gaps (50% duty) in K=2,M=4,N=4 case -> identical buffer contents and indices to first scenario.
- rst_n low during LOAD_B word 1 after 2 bytes -> all outputs 0 immediately; restarting full sequence produces correct writes from index 0.
- s_valid held high during WAIT_LO -> s_ready=0, byte not consumed; accepted as K in the done cycle.

Source files
------------

// File: rtl/gbuf_loader.sv
// gbuf_loader: host byte-stream front end for the TPU core.
// Receives a 3-byte header (K, M, N) and then the operand bytes. It packs the
// bytes into 32-bit words, most significant byte first, and writes them into
// the A and then the B global buffer. It then pulses in_valid with K/M/N and
// waits for one full TPU busy period. Last, it pulses done.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_s_valid, i_s_data, o_s_ready host byte stream (valid/ready)
//   o_a_wr_en, o_a_index, o_a_data_in   A buffer write port
//   o_b_wr_en, o_b_index, o_b_data_in   B buffer write port
//   o_in_valid, o_k, o_m, o_n     TPU start pulse and dimensions
//   i_busy                        TPU busy
//   o_done, o_err                 completion / zero-dimension pulses
module gbuf_loader #(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_s_valid,
   input  logic [7:0]        i_s_data,
   output logic              o_s_ready,
   output logic              o_a_wr_en,
   output logic [ADDR_W-1:0] o_a_index,
   output logic [31:0]       o_a_data_in,
   output logic              o_b_wr_en,
   output logic [ADDR_W-1:0] o_b_index,
   output logic [31:0]       o_b_data_in,
   output logic              o_in_valid,
   output logic [7:0]        o_k,
   output logic [7:0]        o_m,
   output logic [7:0]        o_n,
   input  logic              i_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE, HDR_M, HDR_N, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO
   } state_t;

   state_t              r_state, w_state_nxt;
   logic                r_s_ready, w_ready_nxt;
   logic                r_a_wr_en, r_b_wr_en, r_in_valid, r_done, r_err;
   logic [ADDR_W-1:0]   r_a_index, r_b_index;
   logic [WORD_W-1:0]   r_a_data, r_b_data;
   logic [7:0]          r_k, r_m, r_n;
   logic [CNT_W-1:0]    r_a_words, r_b_words, r_widx;
   logic [1:0]          r_bcnt;
   logic [23:0]         r_word;
   logic                w_acc, w_word_end, w_last_a, w_last_b;
   logic                w_wr_a, w_wr_b, w_in_valid, w_done, w_err;

   // Number of 4-lane blocks that cover a dimension (ceil(d/4)).
   function automatic logic [CNT_W-1:0] f_blocks(input logic [7:0] d);
      return CNT_W'((9'(d) + 9'd3) >> 2);
   endfunction

   assign w_acc      = i_s_valid & r_s_ready;
   assign w_word_end = w_acc & (r_bcnt == 2'd3);
   assign w_last_a   = (r_widx == r_a_words - CNT_W'(1));
   assign w_last_b   = (r_widx == r_b_words - CNT_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and per-cycle strobe decode.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_a      = 1'b0;
      w_wr_b      = 1'b0;
      w_in_valid  = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         IDLE:    if (w_acc) w_state_nxt = HDR_M;
         HDR_M:   if (w_acc) w_state_nxt = HDR_N;
         HDR_N: begin
            if (w_acc) begin
               if ((r_k == 8'd0) || (r_m == 8'd0) || (i_s_data == 8'd0)) begin
                  w_err       = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = LOAD_A;
               end
            end
         end
         LOAD_A: begin
            if (w_word_end) begin
               w_wr_a = 1'b1;
               if (w_last_a) w_state_nxt = LOAD_B;
            end
         end
         LOAD_B: begin
            if (w_word_end) begin
               w_wr_b = 1'b1;
               if (w_last_b) w_state_nxt = START;
            end
         end
         START: begin
            w_in_valid  = 1'b1;
            w_state_nxt = WAIT_HI;
         end
         // busy is ignored while the start pulse itself is still on the wire
         WAIT_HI: if (i_busy && !r_in_valid) w_state_nxt = WAIT_LO;
         WAIT_LO: begin
            if (!i_busy) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Ready is registered from the next state so it is low while in reset.
   assign w_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == HDR_M) ||
                        (w_state_nxt == HDR_N) || (w_state_nxt == LOAD_A) ||
                        (w_state_nxt == LOAD_B);

   // Registered control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_ready  <= 1'b0;
         r_a_wr_en  <= 1'b0;
         r_b_wr_en  <= 1'b0;
         r_in_valid <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_s_ready  <= w_ready_nxt;
         r_a_wr_en  <= w_wr_a;
         r_b_wr_en  <= w_wr_b;
         r_in_valid <= w_in_valid;
         r_done     <= w_done;
         r_err      <= w_err;
      end
   end

   // Header capture, byte packing and buffer write payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k       <= '0;
         r_m       <= '0;
         r_n       <= '0;
         r_a_words <= '0;
         r_b_words <= '0;
         r_widx    <= '0;
         r_bcnt    <= '0;
         r_word    <= '0;
         r_a_index <= '0;
         r_b_index <= '0;
         r_a_data  <= '0;
         r_b_data  <= '0;
      end else begin
         if (w_acc) begin
            case (r_state)
               IDLE:  r_k <= i_s_data;
               HDR_M: r_m <= i_s_data;
               HDR_N: begin
                  r_n       <= i_s_data;
                  r_a_words <= f_blocks(r_m) * CNT_W'(r_k);
                  r_b_words <= f_blocks(i_s_data) * CNT_W'(r_k);
                  r_widx    <= '0;
                  r_bcnt    <= '0;
               end
               LOAD_A, LOAD_B: begin
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     // word index restarts at 0 for the B phase
                     if ((w_wr_a && w_last_a) || (w_wr_b && w_last_b)) r_widx <= '0;
                     else                                              r_widx <= r_widx + CNT_W'(1);
                  end else begin
                     r_word <= {r_word[15:0], i_s_data};
                  end
               end
               default: ;
            endcase
         end
         if (w_wr_a) begin
            r_a_index <= ADDR_W'(r_widx);
            r_a_data  <= {r_word, i_s_data};
         end
         if (w_wr_b) begin
            r_b_index <= ADDR_W'(r_widx);
            r_b_data  <= {r_word, i_s_data};
         end
      end
   end

   assign o_s_ready   = r_s_ready;
   assign o_a_wr_en   = r_a_wr_en;
   assign o_a_index   = r_a_index;
   assign o_a_data_in = r_a_data;
   assign o_b_wr_en   = r_b_wr_en;
   assign o_b_index   = r_b_index;
   assign o_b_data_in = r_b_data;
   assign o_in_valid  = r_in_valid;
   assign o_k         = r_k;
   assign o_m         = r_m;
   assign o_n         = r_n;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule
